// File: rtl/adder_sum_accum_if.sv
// Bus between the adder result stream, the frame accumulator and the total consumer.
// The master drives the adder-side signals and the consumer's ready; the slave returns
// the frame totals and the error flags.
interface adder_sum_accum_if #(
   parameter int ACC_W = 16
);
   logic             launch_valid;
   logic             clear;
   logic             res_cout;
   logic [7:0]       res_sum;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_total;
   logic             drop_err;
   logic             wrap_err;

   modport master (
      output launch_valid, clear, res_cout, res_sum, out_ready,
      input  out_valid, out_total, drop_err, wrap_err
   );

   modport slave (
      input  launch_valid, clear, res_cout, res_sum, out_ready,
      output out_valid, out_total, drop_err, wrap_err
   );
endinterface

// File: rtl/adder_sum_accum.sv
// Frame accumulator behind the two-stage 8-bit adder.
// A two-deep valid delay line follows each operand launch through the adder. The block
// then sums FRAME_LEN 9-bit results {cout,sum} into one frame total and hands that total
// out over a valid/ready port.
// Optional macro ACCUM_SAT_EN: an accumulator overflow saturates to all-ones instead of
// wrapping modulo 2^ACC_W. wrap_err is set in both builds.
module adder_sum_accum #(
   parameter int FRAME_LEN = 4,   // 1..255
   parameter int ACC_W     = 16   // 10..32
) (
   input  logic              clk,
   input  logic              rst_n,
   adder_sum_accum_if.slave  bus
);
   localparam logic [7:0] CNT_LAST = 8'(FRAME_LEN - 1);

   // vld_pipe[0] = v1 (launch seen), vld_pipe[1] = v2 (result on res_* this cycle)
   logic [1:0]       vld_pipe;
   logic [7:0]       cnt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] out_total_q;
   logic             out_valid_q;
   logic             drop_q;
   logic             wrap_q;

   logic [8:0]       res9;
   logic [ACC_W:0]   sum_ext;
   logic             carry;
   logic [ACC_W-1:0] acc_add;
   logic             take;
   logic             frame_end;
   logic             slot_free;

   assign res9    = {bus.res_cout, bus.res_sum};
   assign sum_ext = {1'b0, acc} + {{(ACC_W-8){1'b0}}, res9};
   assign carry   = sum_ext[ACC_W];

`ifdef ACCUM_SAT_EN
   // once saturated, acc stays all-ones until the frame end zeroes it
   assign acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
   assign acc_add = sum_ext[ACC_W-1:0];
`endif

   assign take      = vld_pipe[1] & ~bus.clear;
   assign frame_end = take & (cnt == CNT_LAST);
   // the slot is free when it is empty or when it empties on this edge
   assign slot_free = ~out_valid_q | bus.out_ready;

   // Valid delay line. It is aligned with the adder's two pipeline stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         vld_pipe <= '0;
      else if (bus.clear) vld_pipe <= '0;
      else                vld_pipe <= {vld_pipe[0], bus.launch_valid};
   end

   // Running frame sum and result count. Both restart at each frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (bus.clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (frame_end) begin
         acc <= '0;
         cnt <= '0;
      end else if (take) begin
         acc <= acc_add;
         cnt <= cnt + 8'd1;
      end
   end

   // Output slot. A frame end and an accept on the same edge reload the slot with no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_total_q <= '0;
      end else if (bus.clear) begin
         out_valid_q <= 1'b0;
      end else if (frame_end && slot_free) begin
         out_valid_q <= 1'b1;
         out_total_q <= acc_add;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Sticky error flags. Only reset and clear drop them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= 1'b0;
         wrap_q <= 1'b0;
      end else if (bus.clear) begin
         drop_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         if (frame_end && !slot_free) drop_q <= 1'b1;
         if (take && carry)           wrap_q <= 1'b1;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_total = out_total_q;
   assign bus.drop_err  = drop_q;
   assign bus.wrap_err  = wrap_q;
endmodule

// File: doc/adder_sum_accum.md
Name: adder_sum_accum

Overview:
- Downstream consumer of the 8-bit two-stage pipelined adder.
- Tracks adder latency with a 2-deep valid delay line aligned to operand launch.
- Accumulates each 9-bit result {cout,sum} into a running frame total, and emits one total per FRAME_LEN results over a valid/ready output handshake.
- Sits between the adder datapath and the result-consuming logic, for example a bus/register interface.

Parameters:
- FRAME_LEN, 4: results summed per frame; legal range 1..255.
- ACC_W, 16: accumulator and out_total width; legal range 10..32.

Ports:
- clk  input  1  rising-edge clock, shared with the adder.
- rst_n  input  1  asynchronous, active-low reset.
- launch_valid  input  1  high in the cycle operands are presented to the adder.
- clear  input  1  synchronous flush.
- res_cout  input  1  adder cout.
- res_sum  input  8  adder sum.
- out_valid  output  1  frame total available.
- out_ready  input  1  consumer accepts out_total.
- out_total  output  ACC_W  completed frame sum.
- drop_err  output  1  sticky: a frame was lost because the output was occupied.
- wrap_err  output  1  sticky: the accumulator exceeded 2^ACC_W-1.

Behaviour:
- Reset (rst_n=0, asynchronous) clears all state to zero: v1, v2, acc, cnt, out_valid, out_total, drop_err, wrap_err.
- Valid delay line: v1<=launch_valid, v2<=v1 on each rising edge.
  - When v2=1, res_cout/res_sum carry the result of the launch two edges earlier.
  - The block samples them on the next edge, so total latency from launch to accumulation is 3 edges.
- res9 = {res_cout,res_sum}, zero-extended to ACC_W+1 bits for the add.
- Edge with v2=1, clear=0, cnt<FRAME_LEN-1: acc<=acc+res9 (low ACC_W bits); cnt<=cnt+1.
- Edge with v2=1, clear=0, cnt==FRAME_LEN-1 (frame end):
  - total=acc+res9; acc<=0; cnt<=0.
  - Output slot free (out_valid=0, or out_valid&out_ready in the same cycle): out_total<=total, out_valid<=1.
  - Otherwise: frame discarded, out_total unchanged, drop_err<=1.
- Wrap: if the carry out of bit ACC_W-1 is set in any accumulate, the sum wraps modulo 2^ACC_W and wrap_err<=1.
- Output handshake:
  - out_valid and out_total hold stable until out_valid&out_ready.
  - On that edge out_valid<=0, unless a new frame ends on the same edge, in which case out_valid stays 1 with the new total (back-to-back, no bubble).
- clear=1 takes priority over v2 and launch_valid:
  - v1, v2, acc, cnt, out_valid <=0; drop_err, wrap_err <=0; out_total unchanged.
  - Results in flight are discarded.
- FRAME_LEN=1: every valid result is a frame end; out_total=res9.
- No backpressure to the adder; the adder cannot stall, so an overrun is reported only via drop_err.
- cnt width: 8 bits.

Optional Feature:
- Macro: ACCUM_SAT_EN.
- Defined: an accumulate whose true sum exceeds 2^ACC_W-1 yields all-ones (saturates) instead of wrapping; wrap_err is still set; saturation persists until the frame end resets acc.
- Undefined: modulo wrap as above.

Test Plan:
1. Reset then single launch: launch_valid pulse with adder operands 0x0F+0x01+cin0; FRAME_LEN=1 -> 3 edges later out_valid=1, out_total=0x0010; out_ready=1 clears out_valid next edge.
2. Frame of 4: launches 0xFF+0xFF+1 (0x1FF) four times back-to-back -> one out_valid with out_total=0x07FC, 3 edges after the last launch.
3. Backpressure: out_ready=0, two full frames -> first total held stable, drop_err=1 after the second frame end, out_total still the first value; out_ready=1 then clear -> drop_err=0.
4. Simultaneous accept and frame end: out_ready=1 on the same edge a new frame completes -> out_valid stays 1, out_total updates to the new value, drop_err stays 0.
5. Wrap/saturate with ACC_W=10, FRAME_LEN=4, four results of 0x1FF (sum 0x7FC):
   - without macro: out_total=0x3FC, wrap_err=1;
   - with ACCUM_SAT_EN: out_total=0x3FF, wrap_err=1.
6. Mid-operation disturbances:
   - clear asserted one edge after launch -> no accumulate, cnt=0, out_valid=0.
   - rst_n low mid-frame (asynchronous, between edges) -> all outputs 0 immediately.
